// File: rtl/rr_burst_arbiter_if.sv
// Stream bundle between the serializer channels, the round-robin burst
// arbiter and the downstream bridge. The arbiter uses the slave view; the
// channel/bridge side uses the master view.
interface rr_burst_arbiter_if #(
  parameter int BUS_WIDTH = 128,
  parameter int LEVELS    = 7
);
  localparam int ID_WIDTH = $clog2(LEVELS);

  logic [LEVELS-1:0]           in_valid;
  logic [LEVELS*BUS_WIDTH-1:0] in_stream;
  logic [LEVELS-1:0]           in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [BUS_WIDTH-1:0]        out_stream;
  logic [ID_WIDTH-1:0]         out_id;
  logic                        out_last;

  modport slave (
    input  in_valid, in_stream, out_ready,
    output in_ready, out_valid, out_stream, out_id, out_last
  );

  modport master (
    output in_valid, in_stream, out_ready,
    input  in_ready, out_valid, out_stream, out_id, out_last
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one channel owns the output for up to MAX_BEATS
// beats, then priority rotates to the channel after it. Each beat carries the
// owning channel index so downstream address generation can route it.
module rr_burst_arbiter #(
  parameter int BUS_WIDTH = 128,
  parameter int LEVELS    = 7,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_burst_arbiter_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(LEVELS);
  localparam int CNT_W    = $clog2(MAX_BEATS + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_r;
  logic [ID_WIDTH-1:0] grant_id_r;
  logic [ID_WIDTH-1:0] rr_ptr_r;
  logic [CNT_W-1:0]    beat_cnt_r;

  logic                found_s;
  logic [ID_WIDTH-1:0] pick_s;
  logic [ID_WIDTH-1:0] next_ptr_s;
  logic                last_beat_s;
  logic                out_valid_s;
  logic [LEVELS-1:0]   in_ready_s;

  // Channel index base+off, wrapped modulo LEVELS (LEVELS need not be a power of two).
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= LEVELS) begin
      wrap_add = ID_WIDTH'(sum - LEVELS);
    end else begin
      wrap_add = ID_WIDTH'(sum);
    end
  endfunction

  // First requesting channel found searching upward from rr_ptr, wrapping at LEVELS-1.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (!found_s && bus.in_valid[wrap_add(rr_ptr_r, i)]) begin
        found_s = 1'b1;
        pick_s  = wrap_add(rr_ptr_r, i);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign next_ptr_s  = wrap_add(grant_id_r, 1);
  assign last_beat_s = (beat_cnt_r == CNT_W'(MAX_BEATS - 1));

  // Output mux: only the granted channel is visible; everything is zero in IDLE.
  always_comb begin
    out_valid_s = 1'b0;
    in_ready_s  = '0;
    if (state_r == GRANT) begin
      out_valid_s            = bus.in_valid[grant_id_r];
      in_ready_s[grant_id_r] = bus.out_ready;
    end else begin
      out_valid_s = 1'b0;
      in_ready_s  = '0;
    end
  end

  assign bus.out_valid  = out_valid_s;
  assign bus.in_ready   = in_ready_s;
  assign bus.out_stream = (state_r == GRANT) ?
                          bus.in_stream[int'(grant_id_r)*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign bus.out_id     = (state_r == GRANT) ? grant_id_r : '0;
  assign bus.out_last   = out_valid_s && last_beat_s;

  // Arbitration FSM: pick a channel in IDLE, count beats in GRANT, rotate on burst end or release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_id_r <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= GRANT;
          end else begin
            state_r    <= IDLE;
          end
        end
        GRANT: begin
          if (!bus.in_valid[grant_id_r]) begin
            // Channel dropped its request: give up the rest of the burst.
            state_r    <= IDLE;
            rr_ptr_r   <= next_ptr_s;
            beat_cnt_r <= '0;
          end else if (bus.out_ready) begin
            if (last_beat_s) begin
              state_r    <= IDLE;
              rr_ptr_r   <= next_ptr_s;
              beat_cnt_r <= '0;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
          end else begin
            // Backpressure: hold grant and count until the beat is accepted.
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_id_r <= '0;
          rr_ptr_r   <= '0;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed testbench for rr_burst_arbiter (BUS_WIDTH 128, LEVELS 7, MAX_BEATS 8).
module tb_rr_burst_arbiter;
  localparam int BW = 128;
  localparam int LV = 7;
  localparam int MB = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cnt [LV];
  logic [11:0]   obs;
  logic [11:0]   exp_v;
  logic [BW-1:0] exp_d;

  rr_burst_arbiter_if #(.BUS_WIDTH(BW), .LEVELS(LV)) bus ();

  rr_burst_arbiter #(.BUS_WIDTH(BW), .LEVELS(LV), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.out_valid, bus.out_id, bus.in_ready, bus.out_last};

  function automatic logic [BW-1:0] data_of(input int k, input int n);
    data_of = {16'hA5A5, 16'(k), 32'(n), 32'hDEAD_BEEF ^ 32'(k), 32'(n * 13 + k)};
  endfunction

  task automatic build_stream();
    for (int k = 0; k < LV; k++) bus.in_stream[k*BW +: BW] = data_of(k, cnt[k]);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < LV; k++) cnt[k] = 0;
    build_stream();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < LV; k++) cnt[k] = 0;
    build_stream();
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if (obs !== 12'h000 || bus.out_stream !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h expected 000/0", obs, bus.out_stream);
    end
    bus.in_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL idle_no_req cycle %0d: got %h expected 000", c, obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_channel();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 7'b0001000;
    for (int b = 0; b < 2; b++) begin
      build_stream();
      @(negedge clk);
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL single_gap burst %0d: got %h expected 000", b, obs);
      end
      @(posedge clk); #1;
      for (int beat = 0; beat < MB; beat++) begin
        build_stream();
        @(negedge clk);
        exp_v = {1'b1, 3'd3, 7'b0001000, (beat == MB - 1)};
        exp_d = data_of(3, cnt[3]);
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL single_beat b%0d/%0d: got %h expected %h", b, beat, obs, exp_v);
        end
        n_checks++;
        if (bus.out_stream !== exp_d) begin
          n_fail++;
          $display("FAIL single_data b%0d/%0d: got %h expected %h", b, beat, bus.out_stream, exp_d);
        end
        @(posedge clk);
        cnt[3]++;
        #1;
      end
    end
    bus.in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL single_end: got %h expected 000", obs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_channels();
    int ch;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = '1;
    for (int g = 0; g < LV + 1; g++) begin
      ch = g % LV;
      build_stream();
      @(negedge clk);
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL rr_gap grant %0d: got %h expected 000", g, obs);
      end
      @(posedge clk); #1;
      for (int beat = 0; beat < MB; beat++) begin
        build_stream();
        @(negedge clk);
        exp_v = {1'b1, 3'(ch), 7'(1 << ch), (beat == MB - 1)};
        exp_d = data_of(ch, cnt[ch]);
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL rr_beat g%0d/%0d: got %h expected %h", g, beat, obs, exp_v);
        end
        n_checks++;
        if (bus.out_stream !== exp_d) begin
          n_fail++;
          $display("FAIL rr_data g%0d/%0d: got %h expected %h", g, beat, bus.out_stream, exp_d);
        end
        @(posedge clk);
        cnt[ch]++;
        #1;
      end
    end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_early_release();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 7'b0100000;
    build_stream();
    @(negedge clk);
    @(posedge clk); #1;
    for (int beat = 0; beat < 3; beat++) begin
      bus.in_valid = 7'b0100010;
      build_stream();
      @(negedge clk);
      exp_v = {1'b1, 3'd5, 7'b0100000, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL release_beat %0d: got %h expected %h", beat, obs, exp_v);
      end
      @(posedge clk);
      cnt[5]++;
      #1;
    end
    bus.in_valid = 7'b0000010;
    build_stream();
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL release_drop: got valid %b last %b expected 0 0", bus.out_valid, bus.out_last);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL release_idle: got %h expected 000", obs);
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_v = {1'b1, 3'd1, 7'b0000010, 1'b0};
    exp_d = data_of(1, 0);
    n_checks++;
    if (obs !== exp_v || bus.out_stream !== exp_d) begin
      n_fail++;
      $display("FAIL release_next: got %h expected %h", obs, exp_v);
    end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int  xfers;
    logic rdy;
    apply_reset();
    xfers = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 7'b0000100;
    build_stream();
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 40 && xfers < MB; i++) begin
      rdy = ((i % 4) == 0) || ((i % 4) == 3);
      bus.out_ready = rdy;
      build_stream();
      @(negedge clk);
      exp_v = {1'b1, 3'd2, (rdy ? 7'b0000100 : 7'b0000000), (xfers == MB - 1)};
      exp_d = data_of(2, xfers);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_ctrl cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      n_checks++;
      if (bus.out_stream !== exp_d) begin
        n_fail++;
        $display("FAIL bp_data cycle %0d: got %h expected %h", i, bus.out_stream, exp_d);
      end
      @(posedge clk);
      if (rdy) begin
        xfers++;
        cnt[2]++;
      end
      #1;
    end
    n_checks++;
    if (xfers != MB) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d transfers expected %0d", xfers, MB);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL bp_release: got %h expected 000", obs);
    end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 7'b1000000;
    build_stream();
    @(negedge clk);
    @(posedge clk); #1;
    for (int beat = 0; beat < 4; beat++) begin
      build_stream();
      @(negedge clk);
      exp_v = {1'b1, 3'd6, 7'b1000000, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mid_beat %0d: got %h expected %h", beat, obs, exp_v);
      end
      if (beat < 3) begin
        @(posedge clk);
        cnt[6]++;
        #1;
      end
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'h000 || bus.out_stream !== '0) begin
      n_fail++;
      $display("FAIL mid_rst_drop: got %h/%h expected 000/0", obs, bus.out_stream);
    end
    bus.in_valid = 7'b1000001;
    build_stream();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_rst_idle: got %h expected 000", obs);
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_v = {1'b1, 3'd0, 7'b0000001, 1'b0};
    exp_d = data_of(0, 0);
    n_checks++;
    if (obs !== exp_v || bus.out_stream !== exp_d) begin
      n_fail++;
      $display("FAIL mid_rst_regrant: got %h expected %h", obs, exp_v);
    end
    bus.in_valid = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_channel();
    test_all_channels();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
